// File: rtl/sync_arith_unit_pipe.sv
// sync_arith_unit_pipe: M-bit 2-stage valid/ready arithmetic unit.
// SUB(A-2B), signed COMP, SUM with bit clear, two's complement -> sign-magnitude.
module sync_arith_unit_pipe #(
  parameter int M = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_op,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_COMP = 2'b01,
    OP_SUM  = 2'b10,
    OP_CONV = 2'b11
  } op_e;

  typedef struct packed {
    logic         vld;
    op_e          op;
    logic [M-1:0] a;
    logic [M-1:0] b;
  } s1_t;

  localparam logic [M-1:0] ONE     = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] MIN_NEG = {1'b1, {(M-1){1'b0}}};

  s1_t          s1;
  logic         s2_adv;
  logic         s1_adv;
  logic         accept;
  logic [M-1:0] sub_b2;
  logic [M+1:0] sub_d;
  logic [M:0]   sum_s;
  logic [M-2:0] neg_lo;
  logic [M-1:0] res;
  logic         carry;
  logic         ovf;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = s2_adv || !s1.vld;
  assign o_ready = !s1.vld || s2_adv;
  assign accept  = i_valid && o_ready;

  // A-2B kept in M+2 bits so overflow is a sign-extension check
  assign sub_b2 = {s1.b[M-2:0], 1'b0};
  assign sub_d  = {{2{s1.a[M-1]}}, s1.a}
                - {s1.b[M-1], s1.b, 1'b0};
  assign sum_s  = {1'b0, s1.a} + {1'b0, s1.b};
  assign neg_lo = '0 - s1.a[M-2:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (s1.op)
      OP_SUB: begin
        res   = sub_d[M-1:0];
        carry = s1.a < sub_b2;
        ovf   = (sub_d[M+1:M-1] != '0)
             && (sub_d[M+1:M-1] != '1);
      end
      OP_COMP: begin
        res = {{(M-1){1'b0}},
               $signed(s1.a) < $signed(s1.b)};
      end
      OP_SUM: begin
        // shift by B >= M yields an all-zero mask
        res   = sum_s[M-1:0] & ~(ONE << s1.b);
        carry = sum_s[M];
        ovf   = (s1.a[M-1] == s1.b[M-1])
             && (sum_s[M-1] != s1.a[M-1]);
      end
      OP_CONV: begin
        res = s1.a[M-1] ? {1'b1, neg_lo} : s1.a;
        ovf = s1.a == MIN_NEG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1       <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_status <= '0;
    end else begin
      if (s1_adv) begin
        s1.vld <= accept;
        if (accept) begin
          s1.op <= op_e'(i_op);
          s1.a  <= i_arg_A;
          s1.b  <= i_arg_B;
        end
      end
      if (s2_adv) begin
        o_valid <= s1.vld;
        if (s1.vld) begin
          o_result <= res;
          o_status <= {carry, ovf, res[M-1], res == '0};
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_arith_unit_pipe.sv
// tb_sync_arith_unit_pipe: random + directed checks of sync_arith_unit_pipe
// against an integer-arithmetic reference model and an in-order queue.
module tb_sync_arith_unit_pipe;

  localparam int M = 8;

  logic         i_clk;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_op;
  logic [M-1:0] i_arg_A;
  logic [M-1:0] i_arg_B;
  logic         o_valid;
  logic         i_ready;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;

  int vectors;
  int miscompares;
  int n_out;

  logic [M+3:0] q[$];
  bit           held;
  logic [M-1:0] held_r;
  logic [3:0]   held_s;

  sync_arith_unit_pipe #(.M(M)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // returns {status[3:0], result[M-1:0]}
  function automatic logic [M+3:0] ref_calc(
    input logic [1:0] op,
    input logic [M-1:0] a,
    input logic [M-1:0] b
  );
    longint md, half, ua, ub, sa, sb, d, r;
    bit c, v;
    logic [M-1:0] rr;
    md = longint'(1) << M;
    half = longint'(1) << (M - 1);
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= half) ? ua - md : ua;
    sb = (ub >= half) ? ub - md : ub;
    c = 0;
    v = 0;
    r = 0;
    case (op)
      2'd0: begin
        d = sa - 2 * sb;
        r = ((d % md) + md) % md;
        v = (d < -half) || (d > half - 1);
        c = ua < ((2 * ub) % md);
      end
      2'd1: r = (sa < sb) ? 1 : 0;
      2'd2: begin
        d = ua + ub;
        c = d >= md;
        r = d % md;
        v = (sa + sb < -half) || (sa + sb > half - 1);
        if (ub < M) r = r & ~(longint'(1) << ub);
      end
      default: begin
        if (ua < half) r = ua;
        else if (ua == half) begin
          r = ua;
          v = 1;
        end else r = half + ((md - ua) % half);
      end
    endcase
    rr = r[M-1:0];
    return {c, v, r >= half, r == 0, rr};
  endfunction

  function automatic logic [M-1:0] rnd_arg();
    case ($urandom_range(0, 5))
      0: return {1'b1, {(M-1){1'b0}}};
      1: return {1'b0, {(M-1){1'b1}}};
      2: return '0;
      3: return '1;
      4: return M'($urandom_range(0, M + 1));
      default: return M'($urandom);
    endcase
  endfunction

  // one clock edge with scoreboard and stall-stability tracking
  task automatic cycle(output bit acc);
    bit con;
    logic [M+3:0] e;
    @(negedge i_clk);
    acc = i_valid && o_ready;
    con = o_valid && i_ready;
    if (held) begin
      vectors++;
      if (o_valid !== 1'b1 || o_result !== held_r
          || o_status !== held_s) begin
        miscompares++;
        $display("FAIL hold: got v=%b r=%h s=%b, want v=1 r=%h s=%b",
                 o_valid, o_result, o_status, held_r, held_s);
      end
    end
    held = o_valid && !i_ready;
    held_r = o_result;
    held_s = o_status;
    if (con) begin
      vectors++;
      n_out++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious: got r=%h s=%b, want no output",
                 o_result, o_status);
      end else begin
        e = q.pop_front();
        if (o_result !== e[M-1:0] || o_status !== e[M+3:M]) begin
          miscompares++;
          $display("FAIL result: got r=%h s=%b, want r=%h s=%b",
                   o_result, o_status, e[M-1:0], e[M+3:M]);
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (acc) q.push_back(ref_calc(i_op, i_arg_A, i_arg_B));
  endtask

  task automatic drive_rnd();
    i_op = 2'($urandom_range(0, 3));
    i_arg_A = rnd_arg();
    i_arg_B = rnd_arg();
  endtask

  task automatic drain();
    bit acc;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() > 0; k++) cycle(acc);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_op = '0;
    i_arg_A = '0;
    i_arg_B = '0;
    #2;
    vectors++;
    if (o_valid !== 1'b0 || o_result !== '0 || o_status !== '0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b r=%h s=%b, want 0/00/0000",
               o_valid, o_result, o_status);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, want 1", o_ready);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] r;
    logic [3:0]   s;
  } vec_t;

  task automatic test_directed();
    vec_t dv[10] = '{
      '{2'd0, 8'h10, 8'h03, 8'h0A, 4'b0000},
      '{2'd0, 8'h05, 8'h03, 8'hFF, 4'b1010},
      '{2'd1, 8'hFE, 8'h01, 8'h01, 4'b0000},
      '{2'd1, 8'h7F, 8'h80, 8'h00, 4'b0001},
      '{2'd2, 8'h03, 8'h02, 8'h01, 4'b0000},
      '{2'd2, 8'h70, 8'h10, 8'h80, 4'b0110},
      '{2'd2, 8'hFF, 8'h01, 8'h00, 4'b1001},
      '{2'd3, 8'hFB, 8'h00, 8'h85, 4'b0010},
      '{2'd3, 8'h80, 8'h00, 8'h80, 4'b0110},
      '{2'd3, 8'h05, 8'h00, 8'h05, 4'b0000}
    };
    i_ready = 1'b1;
    foreach (dv[i]) begin
      i_valid = 1'b1;
      i_op = dv[i].op;
      i_arg_A = dv[i].a;
      i_arg_B = dv[i].b;
      vectors++;
      if (o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_ready[%0d]: got %b, want 1", i, o_ready);
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      vectors++;
      if (o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_early[%0d]: got v=%b, want 0", i, o_valid);
      end
      @(posedge i_clk);
      #1;
      vectors++;
      if (o_valid !== 1'b1 || o_result !== dv[i].r
          || o_status !== dv[i].s) begin
        miscompares++;
        $display("FAIL dir[%0d]: got v=%b r=%h s=%b, want v=1 r=%h s=%b",
                 i, o_valid, o_result, o_status, dv[i].r, dv[i].s);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_back_pressure();
    logic [M-1:0] ba[4];
    logic [M-1:0] bb[4];
    int idx;
    int n0;
    bit acc;
    held = 0;
    n0 = n_out;
    for (int k = 0; k < 4; k++) begin
      ba[k] = rnd_arg();
      bb[k] = rnd_arg();
    end
    idx = 0;
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_op = 2'd2;
    i_arg_A = ba[0];
    i_arg_B = bb[0];
    for (int c = 0; c < 30; c++) begin
      i_ready = (c >= 5);
      cycle(acc);
      if (acc) begin
        idx++;
        if (idx < 4) begin
          i_arg_A = ba[idx];
          i_arg_B = bb[idx];
        end else i_valid = 1'b0;
      end
      if (c == 1) begin
        vectors++;
        if (idx !== 2 || o_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_ready: got accepts=%0d rdy=%b, want 2/0",
                   idx, o_ready);
        end
      end
      if (idx == 4 && q.size() == 0) break;
    end
    i_valid = 1'b0;
    vectors++;
    if (n_out - n0 !== 4 || idx !== 4) begin
      miscompares++;
      $display("FAIL bp_count: got in=%0d out=%0d, want 4/4",
               idx, n_out - n0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n0;
    bit acc;
    held = 0;
    n0 = n_out;
    i_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      i_valid = (c < 16);
      drive_rnd();
      if (c < 16) begin
        vectors++;
        if (o_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready[%0d]: got %b, want 1", c, o_ready);
        end
      end
      cycle(acc);
    end
    vectors++;
    if (n_out - n0 !== 16) begin
      miscompares++;
      $display("FAIL b2b_tput: got %0d results, want 16", n_out - n0);
    end
    drain();
  endtask

  task automatic test_reset_flush();
    bit acc;
    logic [M+3:0] e;
    held = 0;
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive_rnd();
    cycle(acc);
    drive_rnd();
    cycle(acc);
    i_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_fill: got v=%b rdy=%b, want 1/0",
               o_valid, o_ready);
    end
    #3;
    i_reset = 1'b1;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_result !== '0 || o_status !== '0) begin
      miscompares++;
      $display("FAIL flush_clear: got v=%b r=%h s=%b, want 0/00/0000",
               o_valid, o_result, o_status);
    end
    q.delete();
    held = 0;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ghost: got v=%b, want 0", o_valid);
    end
    i_valid = 1'b1;
    drive_rnd();
    e = ref_calc(i_op, i_arg_A, i_arg_B);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_early: got v=%b, want 0", o_valid);
    end
    @(posedge i_clk);
    #1;
    vectors++;
    if (o_valid !== 1'b1 || o_result !== e[M-1:0]
        || o_status !== e[M+3:M]) begin
      miscompares++;
      $display("FAIL flush_lat: got v=%b r=%h s=%b, want v=1 r=%h s=%b",
               o_valid, o_result, o_status, e[M-1:0], e[M+3:M]);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_random();
    bit acc;
    held = 0;
    for (int c = 0; c < 600; c++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 7);
      drive_rnd();
      cycle(acc);
    end
    drain();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n_out = 0;
    held = 0;
    test_reset();
    test_directed();
    test_back_pressure();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
